// File: rtl/axi_crossbar_decerr.sv
// axi_crossbar_decerr
// Decode-error responder for one crossbar slave interface. Rejected writes
// have their W beats drained and get a DECERR B response. Rejected reads
// get arlen+1 DECERR R beats with zero data.
// Optional feature macro: AXI_CROSSBAR_DECERR_STATS_EN adds saturating
// completion counters stat_wr_count / stat_rd_count.
module axi_crossbar_decerr #(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // write decode-error command
  input  logic [ID_WIDTH-1:0]   s_wc_id,
  input  logic                  s_wc_valid,
  output logic                  s_wc_ready,
  // W sink
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  // B source
  output logic [ID_WIDTH-1:0]   m_axi_bid,
  output logic [1:0]            m_axi_bresp,
  output logic                  m_axi_bvalid,
  input  logic                  m_axi_bready,
  // read decode-error command
  input  logic [ID_WIDTH-1:0]   s_rc_id,
  input  logic [7:0]            s_rc_len,
  input  logic                  s_rc_valid,
  output logic                  s_rc_ready,
  // R source
  output logic [ID_WIDTH-1:0]   m_axi_rid,
  output logic [DATA_WIDTH-1:0] m_axi_rdata,
  output logic [1:0]            m_axi_rresp,
  output logic                  m_axi_rlast,
  output logic                  m_axi_rvalid,
  input  logic                  m_axi_rready
`ifdef AXI_CROSSBAR_DECERR_STATS_EN
  ,
  output logic [15:0]           stat_wr_count,
  output logic [15:0]           stat_rd_count
`endif
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [7:0]            cnt_q, cnt_d;

  // Write FSM next state: take command, drain W until wlast, then hold B until accepted
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_wc_valid) begin
          bid_d     = s_wc_id;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && s_axi_wlast) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (m_axi_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM state and captured BID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
    end
  end

  // Read FSM next state: load remaining-beat count, count down to the last beat
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    cnt_d     = cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_rc_valid) begin
          rid_d     = s_rc_id;
          cnt_d     = s_rc_len;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (m_axi_rready) begin
          if (cnt_q == '0) begin
            r_state_d = R_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM state, captured RID and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      cnt_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      cnt_q     <= cnt_d;
    end
  end

  // All handshake outputs come straight from state registers
  assign s_wc_ready   = (w_state_q == W_IDLE);
  assign s_axi_wready = (w_state_q == W_DATA);
  assign m_axi_bvalid = (w_state_q == W_RESP);
  assign m_axi_bid    = bid_q;
  assign m_axi_bresp  = RESP_DECERR;

  assign s_rc_ready   = (r_state_q == R_IDLE);
  assign m_axi_rvalid = (r_state_q == R_DATA);
  // counter sits at zero after a completed burst, so rlast is qualified by state
  assign m_axi_rlast  = (r_state_q == R_DATA) && (cnt_q == '0);
  assign m_axi_rid    = rid_q;
  assign m_axi_rdata  = '0;
  assign m_axi_rresp  = RESP_DECERR;

`ifdef AXI_CROSSBAR_DECERR_STATS_EN
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_rd_q, stat_rd_d;

  // Saturating completion counters
  always_comb begin
    stat_wr_d = stat_wr_q;
    stat_rd_d = stat_rd_q;
    if (m_axi_bvalid && m_axi_bready && (stat_wr_q != '1)) begin
      stat_wr_d = stat_wr_q + 16'd1;
    end
    if (m_axi_rvalid && m_axi_rready && m_axi_rlast && (stat_rd_q != '1)) begin
      stat_rd_d = stat_rd_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_rd_q <= stat_rd_d;
    end
  end

  assign stat_wr_count = stat_wr_q;
  assign stat_rd_count = stat_rd_q;
`endif

endmodule

// File: tb/tb_axi_crossbar_decerr.sv
// Scoreboard bench for axi_crossbar_decerr: expected B/R responses are queued
// when commands are issued and checked by a negedge monitor on each handshake.
module tb_axi_crossbar_decerr;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_wc_id;
  logic        s_wc_valid;
  logic        s_wc_ready;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [7:0]  s_rc_id;
  logic [7:0]  s_rc_len;
  logic        s_rc_valid;
  logic        s_rc_ready;
  logic [7:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
`ifdef AXI_CROSSBAR_DECERR_STATS_EN
  logic [15:0] stat_wr_count;
  logic [15:0] stat_rd_count;
`endif

  axi_crossbar_decerr #(.ID_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_wc_id      (s_wc_id),
    .s_wc_valid   (s_wc_valid),
    .s_wc_ready   (s_wc_ready),
    .s_axi_wlast  (s_axi_wlast),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .m_axi_bid    (m_axi_bid),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .s_rc_id      (s_rc_id),
    .s_rc_len     (s_rc_len),
    .s_rc_valid   (s_rc_valid),
    .s_rc_ready   (s_rc_ready),
    .m_axi_rid    (m_axi_rid),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
`ifdef AXI_CROSSBAR_DECERR_STATS_EN
    ,
    .stat_wr_count(stat_wr_count),
    .stat_rd_count(stat_rd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected R beat: {last, id}; expected B: id
  logic [8:0] rq[$];
  logic [7:0] bq[$];
  int rbeats = 0;
  int bbeats = 0;
  int wbeats = 0;

  logic       r_stall, b_stall;
  logic [7:0] r_prev_id, b_prev_id;
  logic       r_prev_last;

  // Monitor: inputs change at posedge+1, so negedge sees the values the next edge samples
  always @(negedge clk) begin
    if (!rst_n) begin
      r_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (r_stall) begin
        total++;
        if (m_axi_rvalid !== 1'b1 || m_axi_rid !== r_prev_id || m_axi_rlast !== r_prev_last) begin
          bad++;
          $display("FAIL r_stable: rvalid=%b rid=%h rlast=%b, required 1 %h %b",
                   m_axi_rvalid, m_axi_rid, m_axi_rlast, r_prev_id, r_prev_last);
        end
      end
      if (b_stall) begin
        total++;
        if (m_axi_bvalid !== 1'b1 || m_axi_bid !== b_prev_id) begin
          bad++;
          $display("FAIL b_stable: bvalid=%b bid=%h, required 1 %h", m_axi_bvalid, m_axi_bid, b_prev_id);
        end
      end
      r_stall     = m_axi_rvalid && !m_axi_rready;
      r_prev_id   = m_axi_rid;
      r_prev_last = m_axi_rlast;
      b_stall     = m_axi_bvalid && !m_axi_bready;
      b_prev_id   = m_axi_bid;

      if (m_axi_rvalid && m_axi_rready) begin
        logic [8:0] e;
        rbeats++;
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL r_unexpected: rid=%h rlast=%b, required no beat", m_axi_rid, m_axi_rlast);
        end else begin
          e = rq.pop_front();
          if (m_axi_rid !== e[7:0] || m_axi_rlast !== e[8] ||
              m_axi_rresp !== 2'b11 || m_axi_rdata !== 32'h0) begin
            bad++;
            $display("FAIL r_beat: rid=%h rlast=%b rresp=%b rdata=%h, required %h %b 11 0",
                     m_axi_rid, m_axi_rlast, m_axi_rresp, m_axi_rdata, e[7:0], e[8]);
          end
        end
      end

      if (m_axi_bvalid && m_axi_bready) begin
        logic [7:0] eb;
        bbeats++;
        total++;
        if (bq.size() == 0) begin
          bad++;
          $display("FAIL b_unexpected: bid=%h, required no response", m_axi_bid);
        end else begin
          eb = bq.pop_front();
          if (m_axi_bid !== eb || m_axi_bresp !== 2'b11) begin
            bad++;
            $display("FAIL b_resp: bid=%h bresp=%b, required %h 11", m_axi_bid, m_axi_bresp, eb);
          end
        end
      end

      if (s_axi_wvalid && s_axi_wready) wbeats++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_wc_id = '0; s_wc_valid = 1'b0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    m_axi_bready = 1'b0;
    s_rc_id = '0; s_rc_len = '0; s_rc_valid = 1'b0;
    m_axi_rready = 1'b0;
    #3;
    total++;
    if ({s_wc_ready, s_rc_ready, s_axi_wready, m_axi_bvalid, m_axi_rvalid, m_axi_rlast} !== 6'b110000 ||
        m_axi_bid !== 8'h00 || m_axi_rid !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: wc_rdy=%b rc_rdy=%b wrdy=%b bvalid=%b rvalid=%b rlast=%b bid=%h rid=%h, required 1 1 0 0 0 0 00 00",
               s_wc_ready, s_rc_ready, s_axi_wready, m_axi_bvalid, m_axi_rvalid, m_axi_rlast, m_axi_bid, m_axi_rid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int w0;
    m_axi_bready = 1'b1;
    s_wc_id = 8'h5A; s_wc_valid = 1'b1;
    bq.push_back(8'h5A);
    tick();                                   // command handshake, cycle 0
    s_wc_valid = 1'b0;
    total++;
    if (s_axi_wready !== 1'b1 || s_wc_ready !== 1'b0) begin
      bad++;
      $display("FAIL w_ready_cycle1: wready=%b wc_ready=%b, required 1 0", s_axi_wready, s_wc_ready);
    end
    w0 = wbeats;
    for (int i = 0; i < 4; i++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wlast  = (i == 3);
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    total++;
    if (m_axi_bvalid !== 1'b1 || s_axi_wready !== 1'b0) begin
      bad++;
      $display("FAIL w_bvalid_after_wlast: bvalid=%b wready=%b, required 1 0", m_axi_bvalid, s_axi_wready);
    end
    total++;
    if (wbeats - w0 !== 4) begin
      bad++;
      $display("FAIL w_beat_count: got %0d, required 4", wbeats - w0);
    end
    tick();                                   // B handshake
    total++;
    if (s_wc_ready !== 1'b1 || m_axi_bvalid !== 1'b0 || bq.size() != 0) begin
      bad++;
      $display("FAIL w_back_idle: wc_ready=%b bvalid=%b pending=%0d, required 1 0 0",
               s_wc_ready, m_axi_bvalid, bq.size());
    end
  endtask

  task automatic test_w_early_and_bstall();
    int w0;
    w0 = wbeats;
    m_axi_bready = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (s_axi_wready !== 1'b0) begin
        bad++;
        $display("FAIL w_early_held: wready=%b, required 0", s_axi_wready);
      end
    end
    s_wc_id = 8'hC3; s_wc_valid = 1'b1;
    bq.push_back(8'hC3);
    tick();
    s_wc_valid = 1'b0;
    tick();                                   // held W beat accepted here
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    total++;
    if (wbeats - w0 !== 1 || m_axi_bvalid !== 1'b1) begin
      bad++;
      $display("FAIL w_early_accept: beats=%0d bvalid=%b, required 1 1", wbeats - w0, m_axi_bvalid);
    end
    for (int i = 0; i < 4; i++) tick();       // bready low: monitor checks stability
    m_axi_bready = 1'b1;
    tick();
    total++;
    if (bq.size() != 0 || s_wc_ready !== 1'b1) begin
      bad++;
      $display("FAIL b_after_stall: pending=%0d wc_ready=%b, required 0 1", bq.size(), s_wc_ready);
    end
  endtask

  task automatic test_read_len0();
    m_axi_rready = 1'b1;
    s_rc_id = 8'h03; s_rc_len = 8'd0; s_rc_valid = 1'b1;
    rq.push_back({1'b1, 8'h03});
    tick();
    s_rc_valid = 1'b0;
    total++;
    if (m_axi_rvalid !== 1'b1 || m_axi_rlast !== 1'b1 || s_rc_ready !== 1'b0) begin
      bad++;
      $display("FAIL r0_cycle1: rvalid=%b rlast=%b rc_ready=%b, required 1 1 0",
               m_axi_rvalid, m_axi_rlast, s_rc_ready);
    end
    tick();
    total++;
    if (s_rc_ready !== 1'b1 || m_axi_rvalid !== 1'b0 || rq.size() != 0) begin
      bad++;
      $display("FAIL r0_cycle2: rc_ready=%b rvalid=%b pending=%0d, required 1 0 0",
               s_rc_ready, m_axi_rvalid, rq.size());
    end
  endtask

  task automatic test_read_len255();
    int r0;
    int cyc;
    r0 = rbeats;
    s_rc_id = 8'hA7; s_rc_len = 8'd255; s_rc_valid = 1'b1;
    for (int i = 0; i < 256; i++) rq.push_back({(i == 255), 8'hA7});
    tick();
    s_rc_valid = 1'b0;
    cyc = 0;
    while (rq.size() != 0 && cyc < 1000) begin
      m_axi_rready = (cyc % 2 == 0);
      tick();
      cyc++;
    end
    m_axi_rready = 1'b1;
    total++;
    if (rbeats - r0 !== 256 || rq.size() != 0) begin
      bad++;
      $display("FAIL r255_beats: got %0d pending=%0d, required 256 0", rbeats - r0, rq.size());
    end
    total++;
    if (s_rc_ready !== 1'b1 || m_axi_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL r255_idle: rc_ready=%b rvalid=%b, required 1 0", s_rc_ready, m_axi_rvalid);
    end
    rq.delete();
  endtask

  task automatic test_concurrent();
    int t, r_done, b_done, wsent;
    m_axi_rready = 1'b1; m_axi_bready = 1'b1;
    s_wc_id = 8'h01; s_wc_valid = 1'b1;
    s_rc_id = 8'h02; s_rc_len = 8'd3; s_rc_valid = 1'b1;
    bq.push_back(8'h01);
    for (int i = 0; i < 4; i++) rq.push_back({(i == 3), 8'h02});
    tick();                                   // both commands, cycle 0
    s_wc_valid = 1'b0; s_rc_valid = 1'b0;
    r_done = -1; b_done = -1; wsent = 0;
    t = 0;
    while ((r_done < 0 || b_done < 0) && t < 40) begin
      if (wsent < 2 && s_axi_wready) begin
        s_axi_wvalid = 1'b1;
        s_axi_wlast  = (wsent == 1);
        wsent++;
      end else begin
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
      end
      tick();
      t++;
      if (r_done < 0 && rq.size() == 0) r_done = t;
      if (b_done < 0 && bq.size() == 0) b_done = t;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    total++;
    if (r_done != 4) begin
      bad++;
      $display("FAIL conc_read_done: cycle %0d, required 4", r_done);
    end
    total++;
    if (b_done != 3) begin
      bad++;
      $display("FAIL conc_write_done: cycle %0d, required 3", b_done);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int r0;
    m_axi_rready = 1'b1;
    s_rc_id = 8'h77; s_rc_len = 8'd7; s_rc_valid = 1'b1;
    for (int i = 0; i < 8; i++) rq.push_back({(i == 7), 8'h77});
    tick();
    s_rc_valid = 1'b0;
    tick();                                   // beat 0
    tick();                                   // beat 1; beat 2 now presented
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (m_axi_rvalid !== 1'b0 || s_rc_ready !== 1'b1 || m_axi_rlast !== 1'b0 || m_axi_rid !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_burst: rvalid=%b rc_ready=%b rlast=%b rid=%h, required 0 1 0 00",
               m_axi_rvalid, s_rc_ready, m_axi_rlast, m_axi_rid);
    end
    rq.delete();
    tick();
    rst_n = 1'b1;
    r0 = rbeats;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (rbeats != r0 || m_axi_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_more_beats: beats=%0d rvalid=%b, required 0 0", rbeats - r0, m_axi_rvalid);
    end
`ifdef AXI_CROSSBAR_DECERR_STATS_EN
    total++;
    if (stat_rd_count !== 16'd0 || stat_wr_count !== 16'd0) begin
      bad++;
      $display("FAIL stat_after_reset: rd=%0d wr=%0d, required 0 0", stat_rd_count, stat_wr_count);
    end
`endif
    s_rc_id = 8'h11; s_rc_len = 8'd1; s_rc_valid = 1'b1;
    rq.push_back({1'b0, 8'h11});
    rq.push_back({1'b1, 8'h11});
    tick();
    s_rc_valid = 1'b0;
    tick();
    tick();
    total++;
    if (rq.size() != 0 || s_rc_ready !== 1'b1) begin
      bad++;
      $display("FAIL read_after_reset: pending=%0d rc_ready=%b, required 0 1", rq.size(), s_rc_ready);
    end
`ifdef AXI_CROSSBAR_DECERR_STATS_EN
    total++;
    if (stat_rd_count !== 16'd1) begin
      bad++;
      $display("FAIL stat_rd_one: rd=%0d, required 1", stat_rd_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_w_early_and_bstall();
    test_read_len0();
    test_read_len255();
    test_concurrent();
    test_reset_mid_burst();
    total++;
    if (rq.size() != 0 || bq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: r pending=%0d b pending=%0d, required 0 0", rq.size(), bq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
